// File: rtl/eth10_rx.sv
// 10BASE-T receiver: oversampled Manchester decode, preamble/SFD lock, byte
// delivery with SOF/EOF, NLP link integrity. Optional FCS check: FCS_CHECK_EN.
module eth10_rx #(
  parameter int OVS          = 8,
  parameter int MIN_PRE_BITS = 16,
  parameter int LINK_TO      = 4000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_sof,
  output logic       rx_eof,
  output logic       rx_err,
  output logic       crs,
  output logic       link_ok,
  output logic       led_rx
`ifdef FCS_CHECK_EN
  ,
  output logic       crc_ok
`endif
);
  localparam int CW    = $clog2(2*OVS);
  localparam int BLANK = 3*OVS/4;
  localparam int CEND  = 3*OVS/2;

  typedef enum logic [1:0] {IDLE, HUNT, DATA, DROP} state_t;

  state_t        r_state;
  logic          r_s1, r_s2, r_s3;
  logic [CW-1:0] r_since;
  logic [5:0]    r_pre_cnt;
  logic [2:0]    r_bit_cnt;
  logic          r_last, r_got_byte, r_nlp;
  logic [7:0]    r_sh;
  logic [22:0]   r_link_cnt;
  logic          w_edge, w_acc, w_cend, w_reload, w_err;
  logic [7:0]    w_byte;

  assign w_edge = r_s2 ^ r_s3;
  // Edges inside the blanking window are bit-boundary transitions.
  assign w_acc  = w_edge && (r_state == IDLE || r_since > CW'(BLANK));
  assign w_cend = (r_state != IDLE) && !w_acc && (r_since == CW'(CEND));
  assign w_byte = {r_s2, r_sh[7:1]};
  assign w_err  = (r_bit_cnt != 3'd0) || !r_got_byte;
  assign led_rx = ~crs;

`ifdef FCS_CHECK_EN
  logic [31:0] r_crc;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign w_reload = r_nlp | (rx_eof & ~rx_err & crc_ok);
`else
  assign w_reload = r_nlp | (rx_eof & ~rx_err);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {r_s1, r_s2, r_s3} <= 3'b000;
      r_state    <= IDLE;
      r_since    <= '0;
      r_pre_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_last     <= 1'b0;
      r_got_byte <= 1'b0;
      r_nlp      <= 1'b0;
      r_sh       <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_sof     <= 1'b0;
      rx_eof     <= 1'b0;
      rx_err     <= 1'b0;
      crs        <= 1'b0;
`ifdef FCS_CHECK_EN
      r_crc      <= '1;
      crc_ok     <= 1'b0;
`endif
    end else begin
      {r_s1, r_s2, r_s3} <= {rxd, r_s1, r_s2};
      rx_valid <= 1'b0;
      rx_sof   <= 1'b0;
      rx_eof   <= 1'b0;
      rx_err   <= 1'b0;
      r_nlp    <= 1'b0;
      if (w_acc)                     r_since <= CW'(1);
      else if (r_since != CW'(CEND)) r_since <= r_since + 1'b1;
      case (r_state)
        IDLE: if (w_acc) begin
          r_state   <= HUNT;
          crs       <= 1'b1;
          r_last    <= r_s2;
          r_pre_cnt <= 6'd1;
        end
        HUNT: if (w_cend) begin
          r_state <= IDLE;
          crs     <= 1'b0;
          r_nlp   <= (r_pre_cnt == 6'd2) && !r_last;
        end else if (w_acc) begin
          r_last <= r_s2;
          if (r_s2 != r_last) begin
            if (r_pre_cnt != 6'd63) r_pre_cnt <= r_pre_cnt + 1'b1;
          end else if (r_s2 && r_pre_cnt >= 6'(MIN_PRE_BITS)) begin
            r_state    <= DATA;
            r_bit_cnt  <= '0;
            r_got_byte <= 1'b0;
`ifdef FCS_CHECK_EN
            r_crc      <= '1;
`endif
          end else begin
            r_state <= DROP;
          end
        end
        DATA: if (w_cend) begin
          r_state <= IDLE;
          crs     <= 1'b0;
          rx_eof  <= 1'b1;
          rx_err  <= w_err;
`ifdef FCS_CHECK_EN
          crc_ok  <= !w_err && (r_crc == 32'hDEBB20E3);
`endif
        end else if (w_acc) begin
          r_sh      <= w_byte;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == 3'd7) begin
            rx_data    <= w_byte;
            rx_valid   <= 1'b1;
            rx_sof     <= !r_got_byte;
            r_got_byte <= 1'b1;
`ifdef FCS_CHECK_EN
            r_crc      <= crc_upd(r_crc, w_byte);
            if (!r_got_byte) crc_ok <= 1'b0;
`endif
          end
        end
        default: if (w_cend) begin
          r_state <= IDLE;
          crs     <= 1'b0;
        end
      endcase
    end
  end

  // Reload has priority over the decrement, so a reload on the expiry cycle keeps the link up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_link_cnt <= '0;
      link_ok    <= 1'b0;
    end else begin
      if (w_reload)                r_link_cnt <= 23'(LINK_TO);
      else if (r_link_cnt != '0)   r_link_cnt <= r_link_cnt - 1'b1;
      link_ok <= (r_link_cnt != '0);
    end
  end
endmodule

// File: tb/tb_eth10_rx.sv
// Directed bench for eth10_rx: Manchester line driver, byte scoreboard,
// link/NLP timing and reset abort. Define FCS_CHECK_EN to add the FCS frames.
module tb_eth10_rx;
  localparam int OVS     = 8;
  localparam int MINPRE  = 16;
  localparam int LINK_TO = 1000;
`ifdef FCS_CHECK_EN
  localparam logic FCS = 1'b1;
`else
  localparam logic FCS = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1, rxd = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_sof, rx_eof, rx_err, crs, link_ok, led_rx;
`ifdef FCS_CHECK_EN
  logic       crc_ok;
`endif

  eth10_rx #(.OVS(OVS), .MIN_PRE_BITS(MINPRE), .LINK_TO(LINK_TO)) dut (
    .clk(clk), .rst(rst), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof),
    .rx_eof(rx_eof), .rx_err(rx_err), .crs(crs), .link_ok(link_ok),
    .led_rx(led_rx)
`ifdef FCS_CHECK_EN
    , .crc_ok(crc_ok)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic sof; } exp_t;
  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] frm[$];
  int total = 0, bad = 0;
  int cyc = 0, mid_cyc = 0, fall_cyc = -1, c0 = 0;
  int n_valid = 0, n_eof = 0, n_rise = 0, n_fall = 0;
  logic eof_err = 1'b0, eof_crc = 1'b0, crs_q = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (crs && !crs_q) n_rise++;
      if (!crs && crs_q) begin
        n_fall++;
        if (fall_cyc < 0) fall_cyc = cyc;
      end
      if (rx_valid) begin
        n_valid++;
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("rx_data", 32'(rx_data), 32'(mon_e.d));
          chk("rx_sof", 32'(rx_sof), 32'(mon_e.sof));
        end
      end
      if (rx_eof) begin
        n_eof++;
        eof_err = rx_err;
`ifdef FCS_CHECK_EN
        eof_crc = crc_ok;
`endif
      end
    end
    crs_q = crs;
  end

  task automatic clr();
    n_valid = 0; n_eof = 0; n_rise = 0; n_fall = 0; fall_cyc = -1;
    eof_err = 1'b0; eof_crc = 1'b0;
    exp_q.delete();
  endtask

  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge clk);
  endtask

  // Manchester: a 1 is low-then-high, a 0 is high-then-low.
  task automatic send_bit(input logic b);
    hold(~b, OVS/2);
    mid_cyc = cyc;
    hold(b, OVS/2);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_pre(input int n, input logic first);
    logic b;
    b = first;
    for (int i = 0; i < n; i++) begin send_bit(b); b = ~b; end
  endtask

  task automatic tp_idl();
    hold(1'b1, 20);
    hold(1'b0, 40);
  endtask

  // Preamble + SFD + frm[] (scoreboarded) + dribble bits + TP_IDL.
  task automatic send_frame(input int dribble);
    send_pre(56, 1'b1);
    send_byte(8'hD5);
    for (int i = 0; i < frm.size(); i++) begin
      exp_q.push_back('{d: frm[i], sof: (i == 0)});
      send_byte(frm[i]);
    end
    for (int i = 0; i < dribble; i++) send_bit(i[0] ? 1'b0 : 1'b1);
    tp_idl();
  endtask

`ifdef FCS_CHECK_EN
  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    logic        fb;
    c = '1;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ frm[i][k];
        c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
      end
    return ~c;
  endfunction
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_rx_eof",   32'(rx_eof), 0);
    chk("rst_rx_data",  32'(rx_data), 0);
    chk("rst_crs",      32'(crs), 0);
    chk("rst_link_ok",  32'(link_ok), 0);
    chk("rst_led_rx",   32'(led_rx), 1);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // NLP: 8-clk high pulse; link rises 3 (sync) + 12 (carrier end) + 2 (reload, register) after the fall.
    clr();
    hold(1'b1, 8);
    rxd = 1'b0; c0 = cyc;
    for (int n = 0; n < 40 && !link_ok; n++) @(negedge clk);
    chk("nlp_link_delay", 32'(cyc - c0), 17);
    chk("nlp_crs_bursts", 32'(n_rise), 1);
    chk("nlp_no_valid",   32'(n_valid), 0);
    chk("nlp_no_eof",     32'(n_eof), 0);
    repeat (LINK_TO - 1) @(negedge clk);
    chk("link_before_to", 32'(link_ok), 1);
    @(negedge clk);
    chk("link_after_to",  32'(link_ok), 0);

    // Good frame.
    clr();
    frm = '{8'h55, 8'hA3, 8'h01};
    send_frame(0);
    chk("good_n_valid", 32'(n_valid), 3);
    chk("good_n_eof",   32'(n_eof), 1);
    chk("good_err",     32'(eof_err), 0);
    chk("good_q_empty", 32'(exp_q.size()), 0);
    chk("good_crs_fall", 32'(fall_cyc - mid_cyc), 15);
    // A short frame without a valid FCS must not reload the link when the check is built in.
    chk("good_link", 32'(link_ok), 32'(!FCS));

    // Dribble frame after the link has expired.
    repeat (LINK_TO + 20) @(negedge clk);
    chk("drib_link_pre", 32'(link_ok), 0);
    clr();
    send_frame(3);
    chk("drib_n_valid", 32'(n_valid), 3);
    chk("drib_n_eof",   32'(n_eof), 1);
    chk("drib_err",     32'(eof_err), 1);
    chk("drib_link",    32'(link_ok), 0);

    // 10-bit preamble ending in 1: the SFD's leading 1 repeats it below MIN_PRE_BITS.
    clr();
    send_pre(10, 1'b0);
    send_byte(8'hD5);
    send_byte(8'h55);
    chk("drop_crs_held", 32'(crs), 1);
    chk("drop_no_fall",  32'(n_fall), 0);
    tp_idl();
    chk("drop_n_valid",  32'(n_valid), 0);
    chk("drop_n_eof",    32'(n_eof), 0);

    // Reset in the middle of byte 2, with link up from an NLP.
    clr();
    hold(1'b1, 8);
    hold(1'b0, 40);
    chk("pre_rst_link", 32'(link_ok), 1);
    send_pre(56, 1'b1);
    send_byte(8'hD5);
    send_byte(8'h55);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    chk("pre_rst_valid", 32'(n_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_crs",     32'(crs), 0);
    chk("arst_led",     32'(led_rx), 1);
    chk("arst_link",    32'(link_ok), 0);
    chk("arst_rx_data", 32'(rx_data), 0);
    rxd = 1'b0;
    clr();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    frm = '{8'h55, 8'hA3, 8'h01};
    send_frame(0);
    chk("post_rst_n_valid", 32'(n_valid), 3);
    chk("post_rst_n_eof",   32'(n_eof), 1);
    chk("post_rst_err",     32'(eof_err), 0);

`ifdef FCS_CHECK_EN
    // 60 payload bytes + correct FCS, then the same FCS over a corrupted payload.
    repeat (LINK_TO + 20) @(negedge clk);
    begin
      logic [31:0] fcs;
      frm.delete();
      for (int i = 0; i < 60; i++) frm.push_back(8'(i * 37 + 5));
      fcs = fcs_of(60);
      for (int k = 0; k < 4; k++) frm.push_back(fcs[8*k +: 8]);
      clr();
      send_frame(0);
      chk("fcs_n_valid", 32'(n_valid), 64);
      chk("fcs_crc_ok",  32'(eof_crc), 1);
      chk("fcs_hold",    32'(crc_ok), 1);
      chk("fcs_link",    32'(link_ok), 1);
      repeat (LINK_TO + 20) @(negedge clk);
      frm[10] = frm[10] ^ 8'h04;
      clr();
      send_frame(0);
      chk("bad_fcs_err",  32'(eof_err), 0);
      chk("bad_fcs_crc",  32'(eof_crc), 0);
      chk("bad_fcs_link", 32'(link_ok), 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
